// File: rtl/main_control_unit_pkg.sv
// Shared opcode, ALUop, ALUctr and funct constants plus the control-word type for main_control_unit.
`default_nettype none

package main_control_unit_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_OR    = 3'b010;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_FUNCT = 3'b100;

   localparam logic [2:0] ALUCTR_ADD = 3'b000;
   localparam logic [2:0] ALUCTR_SUB = 3'b001;
   localparam logic [2:0] ALUCTR_AND = 3'b010;
   localparam logic [2:0] ALUCTR_OR  = 3'b011;
   localparam logic [2:0] ALUCTR_SLT = 3'b100;

   localparam logic [3:0] FUNCT_ADD = 4'b0000;
   localparam logic [3:0] FUNCT_SUB = 4'b0010;
   localparam logic [3:0] FUNCT_AND = 4'b0100;
   localparam logic [3:0] FUNCT_OR  = 4'b0101;
   localparam logic [3:0] FUNCT_SLT = 4'b1010;

   typedef struct packed {
      logic       regDst;
      logic       ALUsrc;
      logic       memToReg;
      logic       regWrite;
      logic       memWrite;
      logic       branch;
      logic       jump;
      logic       extop;
      logic [2:0] ALUop;
   } ctrl_t;

   function automatic logic funct_legal(input logic [3:0] f);
      return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND) ||
             (f == FUNCT_OR)  || (f == FUNCT_SLT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/main_control_unit_alu_control.sv
// alu_control: combinational ALUop/funct to ALUctr decode.
`default_nettype none

module alu_control
   import main_control_unit_pkg::*;
(
   input  logic [2:0] ALUop,
   input  logic [5:0] funct,
   output logic [2:0] ALUctr
);

   // Only funct[3:0] carries operation information.
   logic w_unused_funct;
   assign w_unused_funct = ^funct[5:4];

   always_comb begin
      ALUctr = ALUCTR_ADD;
      if (ALUop[2]) begin
         case (funct[3:0])
            FUNCT_ADD: ALUctr = ALUCTR_ADD;
            FUNCT_SUB: ALUctr = ALUCTR_SUB;
            FUNCT_AND: ALUctr = ALUCTR_AND;
            FUNCT_OR:  ALUctr = ALUCTR_OR;
            FUNCT_SLT: ALUctr = ALUCTR_SLT;
            default:   ALUctr = ALUCTR_ADD;
         endcase
      end else begin
         case (ALUop)
            ALUOP_ADD: ALUctr = ALUCTR_ADD;
            ALUOP_SUB: ALUctr = ALUCTR_SUB;
            ALUOP_OR:  ALUctr = ALUCTR_OR;
            ALUOP_AND: ALUctr = ALUCTR_AND;
            default:   ALUctr = ALUCTR_ADD;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/main_control_unit.sv
// main_control_unit: registered MIPS-style main decoder; optional MAIN_CTRL_ILLEGAL_EN adds an illegal-encoding flag.
`default_nettype none

module main_control_unit
   import main_control_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] OP,
   input  logic [5:0] funct,
   output logic       jump,
   output logic       extop,
   output logic       branch,
   output logic       memWrite,
   output logic       memToReg,
   output logic       ALUsrc,
   output logic       regWrite,
   output logic       regDst,
   output logic [2:0] ALUop,
`ifdef MAIN_CTRL_ILLEGAL_EN
   output logic       illegal,
`endif
   output logic [2:0] ALUctr
);

   ctrl_t      w_ctrl;
   logic [2:0] w_aluctr;

   always_comb begin
      w_ctrl = '0;
      case (OP)
         OP_RTYPE: w_ctrl = '{regDst: 1'b1, regWrite: 1'b1, ALUop: ALUOP_FUNCT, default: '0};
         OP_ORI:   w_ctrl = '{ALUsrc: 1'b1, regWrite: 1'b1, ALUop: ALUOP_OR, default: '0};
         OP_LW:    w_ctrl = '{ALUsrc: 1'b1, memToReg: 1'b1, regWrite: 1'b1, extop: 1'b1,
                              ALUop: ALUOP_ADD, default: '0};
         OP_SW:    w_ctrl = '{ALUsrc: 1'b1, memWrite: 1'b1, extop: 1'b1, ALUop: ALUOP_ADD,
                              default: '0};
         OP_BEQ:   w_ctrl = '{branch: 1'b1, extop: 1'b1, ALUop: ALUOP_SUB, default: '0};
         OP_J:     w_ctrl = '{jump: 1'b1, ALUop: ALUOP_ADD, default: '0};
         default:  w_ctrl = '0;
      endcase
   end

   // ALUctr is computed from the unregistered ALUop so it lands in the same cycle as the rest.
   alu_control u_alu_control (
      .ALUop  (w_ctrl.ALUop),
      .funct  (funct),
      .ALUctr (w_aluctr)
   );

`ifdef MAIN_CTRL_ILLEGAL_EN
   logic w_illegal;

   always_comb begin
      w_illegal = 1'b0;
      case (OP)
         OP_RTYPE:                          w_illegal = !funct_legal(funct[3:0]);
         OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: w_illegal = 1'b0;
         default:                           w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal <= 1'b0;
      end else begin
         illegal <= w_illegal;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regDst   <= 1'b0;
         ALUsrc   <= 1'b0;
         memToReg <= 1'b0;
         regWrite <= 1'b0;
         memWrite <= 1'b0;
         branch   <= 1'b0;
         jump     <= 1'b0;
         extop    <= 1'b0;
         ALUop    <= ALUOP_ADD;
         ALUctr   <= ALUCTR_ADD;
      end else begin
         regDst   <= w_ctrl.regDst;
         ALUsrc   <= w_ctrl.ALUsrc;
         memToReg <= w_ctrl.memToReg;
         regWrite <= w_ctrl.regWrite;
         memWrite <= w_ctrl.memWrite;
         branch   <= w_ctrl.branch;
         jump     <= w_ctrl.jump;
         extop    <= w_ctrl.extop;
         ALUop    <= w_ctrl.ALUop;
         ALUctr   <= w_aluctr;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_main_control_unit.sv
// Self-checking bench for main_control_unit: directed vector table plus reset sequences.
`default_nettype none

module tb_main_control_unit;

   logic       clk;
   logic       rst_n;
   logic [5:0] OP;
   logic [5:0] funct;
   logic       jump, extop, branch, memWrite, memToReg, ALUsrc, regWrite, regDst;
   logic [2:0] ALUop, ALUctr;
   logic       illegal_o;

   int checks;
   int errors;

   main_control_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .OP       (OP),
      .funct    (funct),
      .jump     (jump),
      .extop    (extop),
      .branch   (branch),
      .memWrite (memWrite),
      .memToReg (memToReg),
      .ALUsrc   (ALUsrc),
      .regWrite (regWrite),
      .regDst   (regDst),
      .ALUop    (ALUop),
`ifdef MAIN_CTRL_ILLEGAL_EN
      .illegal  (illegal_o),
`endif
      .ALUctr   (ALUctr)
   );

`ifndef MAIN_CTRL_ILLEGAL_EN
   assign illegal_o = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {regDst,ALUsrc,memToReg,regWrite,memWrite,branch,jump,extop,ALUop[2:0],ALUctr[2:0]}
   logic [13:0] w_word;
   assign w_word = {regDst, ALUsrc, memToReg, regWrite, memWrite, branch, jump, extop, ALUop, ALUctr};

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [13:0] exp;
      logic        ill;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic check_word(input string name, input logic [13:0] exp);
      checks++;
      if (w_word !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, w_word, exp);
      end
   endtask

   task automatic check_ill(input string name, input logic exp);
`ifdef MAIN_CTRL_ILLEGAL_EN
      checks++;
      if (illegal_o !== exp) begin
         errors++;
         $display("FAIL %s illegal: got %b expected %b", name, illegal_o, exp);
      end
`else
      if (exp === 1'bx) $display("unexpected x in %s", name);
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;

      vecs[0]  = '{"rtype",        6'b000000, 6'b000000, 14'b10010000_100_000, 1'b0};
      vecs[1]  = '{"ori",          6'b001101, 6'b000000, 14'b01010000_010_011, 1'b0};
      vecs[2]  = '{"lw",           6'b100011, 6'b000000, 14'b01110001_000_000, 1'b0};
      vecs[3]  = '{"sw",           6'b101011, 6'b000000, 14'b01001001_000_000, 1'b0};
      vecs[4]  = '{"beq",          6'b000100, 6'b000000, 14'b00000101_001_001, 1'b0};
      vecs[5]  = '{"j",            6'b000010, 6'b000000, 14'b00000010_000_000, 1'b0};
      vecs[6]  = '{"rtype_back",   6'b000000, 6'b000000, 14'b10010000_100_000, 1'b0};
      vecs[7]  = '{"r_sub",        6'b000000, 6'b000010, 14'b10010000_100_001, 1'b0};
      vecs[8]  = '{"r_and",        6'b000000, 6'b000100, 14'b10010000_100_010, 1'b0};
      vecs[9]  = '{"r_or",         6'b000000, 6'b000101, 14'b10010000_100_011, 1'b0};
      vecs[10] = '{"r_slt",        6'b000000, 6'b001010, 14'b10010000_100_100, 1'b0};
      vecs[11] = '{"r_sub_hiign",  6'b000000, 6'b110010, 14'b10010000_100_001, 1'b0};
      vecs[12] = '{"lw_anyfunct",  6'b100011, 6'b000010, 14'b01110001_000_000, 1'b0};
      vecs[13] = '{"beq_anyfunct", 6'b000100, 6'b001010, 14'b00000101_001_001, 1'b0};
      vecs[14] = '{"ori_anyfunct", 6'b001101, 6'b111111, 14'b01010000_010_011, 1'b0};
      vecs[15] = '{"op_illegal",   6'b111111, 6'b000000, 14'b00000000_000_000, 1'b1};
      vecs[16] = '{"r_bad_funct",  6'b000000, 6'b000111, 14'b10010000_100_000, 1'b1};

      // Reset held with R-type on the inputs.
      rst_n = 1'b0;
      OP    = 6'b000000;
      funct = 6'b000000;
      repeat (3) @(posedge clk);
      #1;
      check_word("reset_hold", 14'b0);
      check_ill("reset_hold", 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_word("reset_release_no_edge", 14'b0);
      @(posedge clk);
      #1;
      check_word("first_edge_after_reset", 14'b10010000_100_000);

      // Table sweep; also confirm old outputs persist until the next edge.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         OP    = vecs[i].op;
         funct = vecs[i].fn;
         #1;
         if (i > 0) check_word({vecs[i].name, "_pre_edge"}, vecs[i-1].exp);
         @(posedge clk);
         #1;
         check_word(vecs[i].name, vecs[i].exp);
         check_ill(vecs[i].name, vecs[i].ill);
      end

      // Asynchronous reset in the middle of a sw cycle.
      @(negedge clk);
      OP    = 6'b101011;
      funct = 6'b000000;
      @(posedge clk);
      #1;
      check_word("sw_before_async", 14'b01001001_000_000);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (memWrite !== 1'b0) begin
         errors++;
         $display("FAIL async_memWrite: got %b expected 0", memWrite);
      end
      check_word("async_reset_word", 14'b0);
      @(posedge clk);
      #1;
      check_word("async_reset_held_edge", 14'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_word("sw_after_release", 14'b01001001_000_000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/main_control_unit.md
MAIN_CONTROL_UNIT -- requirements
Module: main_control

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- OP  in  6  instruction opcode field [31:26]
- funct  in  6  instruction function field [5:0]; only bits [3:0] are decoded
- jump  out  1  select jump target
- extop  out  1  1 = sign-extend immediate, 0 = zero-extend
- branch  out  1  conditional branch (beq)
- memWrite  out  1  data-memory write enable
- memToReg  out  1  write-back source is memory
- ALUsrc  out  1  ALU operand B is the immediate
- regWrite  out  1  register-file write enable
- regDst  out  1  destination register is rd (1) or rt (0)
- ALUop  out  3  ALU operation class
- ALUctr  out  3  final ALU operation

Function
REQ-003 All outputs SHALL be registered: OP and funct sampled on a clk rising edge appear on the outputs after that edge (latency 1 cycle), constant until the next edge.
REQ-004 The opcode decode SHALL follow this table (order: regDst, ALUsrc, memToReg, regWrite, memWrite, branch, jump, extop, ALUop):
- 000000 R-type: 1,0,0,1,0,0,0,0,100
- 001101 ori: 0,1,0,1,0,0,0,0,010
- 100011 lw: 0,1,1,1,0,0,0,1,000
- 101011 sw: 0,1,0,0,1,0,0,1,000
- 000100 beq: 0,0,0,0,0,1,0,1,001
- 000010 j: 0,0,0,0,0,0,1,0,000
REQ-005 Any other OP SHALL decode to all-zero control (NOP): no register write, no memory write, no branch, no jump.
REQ-006 ALUctr encoding SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-007 ALUop to ALUctr mapping SHALL be: 000 -> add, 001 -> sub, 010 -> or, 011 -> and; if ALUop[2] is 1, ALUctr is taken from funct.
REQ-008 funct[3:0] mapping under ALUop[2]=1 SHALL be: 0000 add, 0010 sub, 0100 and, 0101 or, 1010 slt; any other value -> add. funct[5:4] are ignored.
REQ-009 ALUctr SHALL be derived from the same-cycle decoded ALUop and sampled funct, so it has the same latency as the other outputs.

Reset
REQ-010 While rst_n is low, every output SHALL be 0 immediately (asynchronous), which is the NOP control word with ALUctr = add.
REQ-011 After rst_n deasserts, the first rising edge SHALL load normal decode; a reset asserted mid-stream SHALL discard the pending decode.

Configuration
REQ-012 Macro MAIN_CTRL_ILLEGAL_EN, when defined, SHALL add output illegal (1 bit, registered, reset 0). illegal is 1 when OP is not in the REQ-004 table, or when OP = 000000 and funct[3:0] is not in the REQ-008 list.
REQ-013 Without MAIN_CTRL_ILLEGAL_EN, the illegal port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-014 A shared package SHALL hold the opcode constants, the ALUop constants, the ALUctr constants and the funct[3:0] constants.
REQ-015 ALUop/funct decoding SHALL be a combinational sub-module named alu_control (inputs ALUop and funct, output ALUctr), instantiated inside main_control ahead of the output register.

Verification
REQ-016 Reset: hold rst_n=0 with OP=000000 and toggle clk -> all outputs 0; release rst_n, next edge -> regDst=1, regWrite=1, ALUop=100.
REQ-017 Opcode sweep 000000, 001101, 100011, 101011, 000100, 000010 then back to 000000, one per cycle -> each control word matches REQ-004 exactly one cycle after sampling.
REQ-018 R-type funct sweep OP=000000 with funct[3:0] = 0000, 0010, 0100, 0101, 1010 -> ALUctr = 000, 001, 010, 011, 100.
REQ-019 Direct ALUop paths: lw -> ALUctr 000; beq -> 001; ori -> 011 (or). Each holds for any funct value.
REQ-020 Illegal inputs: OP=111111 -> NOP word (with the macro, illegal=1); OP=000000 with funct=000111 -> ALUctr=000 (with the macro, illegal=1).
REQ-021 Asynchronous reset mid-stream: assert rst_n between edges during sw -> memWrite falls to 0 without waiting for a clock edge.
